// File: rtl/video_copper_pkg.sv
// Shared constants and state encoding for the raster-synchronised copper engine.
package video_copper_pkg;

  // List entry opcodes, held in bits [15:12]; any other value is a NOP.
  localparam logic [3:0] OP_END   = 4'h0;
  localparam logic [3:0] OP_WAIT  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  // Video IO register holding the current raster line.
  localparam logic [3:0] IO_VLINE = 4'hC;

  // Line 255 is vblank: it satisfies every WAIT and marks the frame boundary.
  localparam logic [7:0] VLINE_VBLANK = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_FETCH      = 3'd2,
    ST_DECODE     = 3'd3,
    ST_POLL       = 3'd4,
    ST_WRITE      = 3'd5
  } copper_state_e;

endpackage

// File: rtl/copper_listram.sv
// 256x16 display-list RAM: CPU read/write port plus a read-only engine port.
// Both reads are registered and return the pre-write contents when the same
// address is written in the same cycle, so a colliding CPU write wins while
// the engine sees the old entry.
module copper_listram (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wrdata,
  input  logic        cpu_wren,
  output logic [15:0] cpu_rddata,
  input  logic [7:0]  eng_addr,
  output logic [15:0] eng_rddata
);

  logic [15:0] mem [0:255];

  // CPU write port
  always_ff @(posedge clk) begin
    if (cpu_wren) mem[cpu_addr] <= cpu_wrdata;
  end

  // Synchronous reads for both ports; read data clears on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rddata <= '0;
      eng_rddata <= '0;
    end else begin
      cpu_rddata <= mem[cpu_addr];
      eng_rddata <= mem[eng_addr];
    end
  end

endmodule

// File: rtl/video_copper.sv
// Copper engine: once per frame, plays back a list of WAIT/WRITE/END commands
// against the video IO register port, polling vline to stay in raster sync.
//
// Bus handshake: bus_req is a request that, once raised, stays high with
// io_addr/io_wrdata stable until the cycle in which bus_gnt is also high;
// that cycle is the transfer (write if io_wren, else a vline read sampled
// from io_rddata). There is no timeout on a withheld grant.
module video_copper
  import video_copper_pkg::*;
#(
  parameter int POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_enable,
  input  logic [7:0]  list_addr,
  input  logic [15:0] list_wrdata,
  input  logic        list_wren,
  output logic [15:0] list_rddata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [3:0]  io_addr,
  output logic [7:0]  io_wrdata,
  output logic        io_wren,
  input  logic [7:0]  io_rddata,
  output logic        busy,
  output logic [7:0]  pc,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = $clog2(POLL_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_INTERVAL);

  copper_state_e  state, state_n;
  logic [7:0]     pc_n;
  logic [7:0]     prev_line, prev_line_n;
  logic [7:0]     target, target_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]     io_addr_n;
  logic [7:0]     io_wrdata_n;
  logic [15:0]    list_q;
  logic           polling;
  logic           xfer;

  copper_listram u_listram (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (list_addr),
    .cpu_wrdata (list_wrdata),
    .cpu_wren   (list_wren),
    .cpu_rddata (list_rddata),
    .eng_addr   (pc),
    .eng_rddata (list_q)
  );

  assign polling   = (state == ST_WAIT_FRAME) || (state == ST_POLL);
  assign bus_req   = (state == ST_WRITE) || (polling && (cnt == '0));
  assign xfer      = bus_req && bus_gnt;
  assign io_wren   = xfer && (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      prev_line <= '0;
      target    <= '0;
      cnt       <= '0;
      io_addr   <= '0;
      io_wrdata <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      prev_line <= prev_line_n;
      target    <= target_n;
      cnt       <= cnt_n;
      io_addr   <= io_addr_n;
      io_wrdata <= io_wrdata_n;
    end
  end

  // Next-state and datapath updates; disable overrides everything to IDLE
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    prev_line_n = prev_line;
    target_n    = target;
    cnt_n       = cnt;
    io_addr_n   = io_addr;
    io_wrdata_n = io_wrdata;
    case (state)
      ST_IDLE: begin
        pc_n = '0;
        if (ctrl_enable) begin
          state_n   = ST_WAIT_FRAME;
          cnt_n     = CNT_LOAD;
          io_addr_n = IO_VLINE;
        end
      end
      ST_WAIT_FRAME: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (xfer) begin
          prev_line_n = io_rddata;
          if ((prev_line == VLINE_VBLANK) && (io_rddata != VLINE_VBLANK)) begin
            pc_n    = '0;
            state_n = ST_FETCH;
          end else begin
            cnt_n = CNT_LOAD;
          end
        end
      end
      ST_FETCH: state_n = ST_DECODE;
      ST_DECODE: begin
        case (list_q[15:12])
          OP_END: begin
            state_n   = ST_WAIT_FRAME;
            cnt_n     = CNT_LOAD;
            io_addr_n = IO_VLINE;
          end
          OP_WAIT: begin
            state_n   = ST_POLL;
            cnt_n     = CNT_LOAD;
            io_addr_n = IO_VLINE;
            target_n  = list_q[7:0];
          end
          OP_WRITE: begin
            state_n     = ST_WRITE;
            io_addr_n   = list_q[11:8];
            io_wrdata_n = list_q[7:0];
          end
          default: begin
            pc_n    = pc + 8'd1;
            state_n = ST_FETCH;
          end
        endcase
      end
      ST_POLL: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (xfer) begin
          prev_line_n = io_rddata;
          if ((io_rddata >= target) || (io_rddata == VLINE_VBLANK)) begin
            pc_n    = pc + 8'd1;
            state_n = ST_FETCH;
          end else begin
            cnt_n = CNT_LOAD;
          end
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          pc_n    = pc + 8'd1;
          state_n = ST_FETCH;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (!ctrl_enable) begin
      state_n = ST_IDLE;
      pc_n    = '0;
    end
  end

endmodule
